// File: rtl/store_align_unit_pkg.sv
// Shared store/load type encodings and the store-size byte-mask helper.
package store_align_unit_pkg;

    localparam logic [1:0] NOSTORE = 2'b00;
    localparam logic [1:0] SB      = 2'b01;
    localparam logic [1:0] SH      = 2'b10;
    localparam logic [1:0] SW      = 2'b11;

    localparam logic [2:0] NOLOAD  = 3'b000;
    localparam logic [2:0] LB      = 3'b001;
    localparam logic [2:0] LH      = 3'b010;
    localparam logic [2:0] LW      = 3'b011;
    localparam logic [2:0] LBU     = 3'b100;
    localparam logic [2:0] LHU     = 3'b101;

    function automatic logic [3:0] size_mask(input logic [1:0] st);
        logic [3:0] m;
        m = 4'b0000;
        case (st)
            SB:      m = 4'b0001;
            SH:      m = 4'b0011;
            SW:      m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Request and memory-write handshake bundle for the store alignment unit.
interface store_align_unit_if;

    logic        ReqValid;
    logic        ReqReady;
    logic [1:0]  StoreType;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        MemValid;
    logic        MemReady;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  MemWE;

    modport slave (
        input  ReqValid, StoreType, Addr, WData, MemReady,
        output ReqReady, MemValid, MemAddr, MemWData, MemWE
    );

    modport master (
        output ReqValid, StoreType, Addr, WData, MemReady,
        input  ReqReady, MemValid, MemAddr, MemWData, MemWE
    );

endinterface

// File: rtl/store_align_unit_lane_shift.sv
// Spreads a store across an 8-byte window: lanes 0-3 form beat 0, lanes 4-7 beat 1.
module store_lane_shift
    import store_align_unit_pkg::*;
(
    input  logic [1:0]  StoreType,
    input  logic [1:0]  off,
    input  logic [31:0] WData,
    output logic [63:0] LaneData,
    output logic [7:0]  LaneWE
);

    assign LaneData = {32'b0, WData} << {off, 3'b000};
    assign LaneWE   = {4'b0000, size_mask(StoreType)} << off;

endmodule

// File: rtl/store_align_unit.sv
// Turns byte/half/word stores into one or two word-aligned memory write beats.
module store_align_unit
    import store_align_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    store_align_unit_if.slave bus,
    output logic             Busy,
    output logic [CNT_W-1:0] SplitCnt
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        hi_data_q, hi_data_d;
    logic [3:0]         hi_we_q, hi_we_d;
    logic               split_q, split_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        lane_data;
    logic [7:0]         lane_we;
    logic               accept;

    store_lane_shift u_lane_shift (
        .StoreType (bus.StoreType),
        .off       (bus.Addr[1:0]),
        .WData     (bus.WData),
        .LaneData  (lane_data),
        .LaneWE    (lane_we)
    );

    // Ready is masked by reset so nothing is accepted while reset is held.
    assign bus.ReqReady = (state_q == IDLE) && !CPU_RST;
    assign accept       = bus.ReqValid && bus.ReqReady;
    assign bus.MemValid = valid_q;
    assign bus.MemAddr  = addr_q;
    assign bus.MemWData = wdata_q;
    assign bus.MemWE    = we_q;
    assign Busy         = (state_q != IDLE);
    assign SplitCnt     = cnt_q;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        hi_data_d = hi_data_q;
        hi_we_d   = hi_we_q;
        split_d   = split_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && (bus.StoreType != NOSTORE)) begin
                    state_d   = BEAT0;
                    valid_d   = 1'b1;
                    addr_d    = {bus.Addr[31:2], 2'b00};
                    wdata_d   = lane_data[31:0];
                    we_d      = lane_we[3:0];
                    hi_data_d = lane_data[63:32];
                    hi_we_d   = lane_we[7:4];
                    split_d   = |lane_we[7:4];
                    if ((|lane_we[7:4]) && (cnt_q != '1)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (bus.MemReady) begin
                    if (split_q) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + 32'd4;
                        wdata_d = hi_data_q;
                        we_d    = hi_we_q;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        wdata_d = '0;
                        we_d    = '0;
                    end
                end
            end
            BEAT1: begin
                if (bus.MemReady) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    wdata_d = '0;
                    we_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
            hi_data_q <= '0;
            hi_we_q   <= '0;
            split_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            hi_data_q <= hi_data_d;
            hi_we_q   <= hi_we_d;
            split_q   <= split_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: expected beats queued at issue, popped at each accepted beat.
module tb_store_align_unit;
    import store_align_unit_pkg::*;

    localparam int CW = 2;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } beat_t;

    logic          CPU_CLK;
    logic          CPU_RST;
    logic          busy;
    logic [CW-1:0] split_cnt;

    store_align_unit_if bus();

    store_align_unit #(.CNT_W(CW)) u_dut (
        .CPU_CLK  (CPU_CLK),
        .CPU_RST  (CPU_RST),
        .bus      (bus),
        .Busy     (busy),
        .SplitCnt (split_cnt)
    );

    initial CPU_CLK = 1'b0;
    always #5 CPU_CLK = ~CPU_CLK;

    int            n_tot = 0;
    int            n_bad = 0;
    int            stall_n = 0;
    int            wait_c = 0;
    int            beats_seen = 0;
    bit            stalled = 0;
    logic [31:0]   p_a, p_d;
    logic [3:0]    p_we;
    logic [CW-1:0] exp_split = '0;
    beat_t         exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void push_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        beat_t b;
        b.a  = a;
        b.d  = d;
        b.we = we;
        exp_q.push_back(b);
    endfunction

    function automatic void bump_split();
        if (exp_split != '1) exp_split = exp_split + 1'b1;
    endfunction

    function automatic void model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  m;
        logic [7:0]  e;
        logic [63:0] x;
        case (t)
            SB:      m = 4'b0001;
            SH:      m = 4'b0011;
            SW:      m = 4'b1111;
            default: m = 4'b0000;
        endcase
        e = {4'b0000, m} << a[1:0];
        x = {32'b0, d} << (int'(a[1:0]) * 8);
        if (m != 4'b0000) push_beat({a[31:2], 2'b00}, x[31:0], e[3:0]);
        if (e[7:4] != 4'b0000) begin
            push_beat({a[31:2], 2'b00} + 32'd4, x[63:32], e[7:4]);
            bump_split();
        end
    endfunction

    // Memory side: decide MemReady each cycle, score accepted beats, check stall stability.
    always @(negedge CPU_CLK) begin
        beat_t b;
        if (CPU_RST) begin
            wait_c       = 0;
            stalled      = 0;
            bus.MemReady = 1'b1;
        end else begin
            if (stalled) begin
                chk("hold_addr", bus.MemAddr, p_a);
                chk("hold_data", bus.MemWData, p_d);
                chk("hold_we", bus.MemWE, p_we);
                chk("hold_rdy", bus.ReqReady, 1'b0);
            end
            if (bus.MemValid) begin
                if (wait_c < stall_n) begin
                    bus.MemReady = 1'b0;
                    wait_c++;
                    stalled = 1;
                    p_a  = bus.MemAddr;
                    p_d  = bus.MemWData;
                    p_we = bus.MemWE;
                end else begin
                    bus.MemReady = 1'b1;
                    wait_c  = 0;
                    stalled = 0;
                    beats_seen++;
                    if (exp_q.size() == 0) begin
                        chk("extra_beat", 1'b1, 1'b0);
                    end else begin
                        b = exp_q.pop_front();
                        chk("beat_addr", bus.MemAddr, b.a);
                        chk("beat_data", bus.MemWData, b.d);
                        chk("beat_we", bus.MemWE, b.we);
                    end
                end
            end else begin
                bus.MemReady = 1'b1;
                stalled = 0;
            end
        end
    end

    task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge CPU_CLK);
        while (!bus.ReqReady && n < 200) begin
            @(negedge CPU_CLK);
            n++;
        end
        if (n >= 200) chk("ready_timeout", 1'b0, 1'b1);
        bus.ReqValid  = 1'b1;
        bus.StoreType = t;
        bus.Addr      = a;
        bus.WData     = d;
        @(posedge CPU_CLK);
        #1;
        bus.ReqValid  = 1'b0;
        bus.StoreType = SW;
        bus.Addr      = $urandom;
        bus.WData     = $urandom;
        if (t != NOSTORE) chk("latency", bus.MemValid, 1'b1);
        else              chk("nostore_idle", busy, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge CPU_CLK);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 1'b0, 1'b1);
        @(negedge CPU_CLK);
        chk("idle_valid", bus.MemValid, 1'b0);
        chk("idle_we", bus.MemWE, 4'b0000);
        chk("idle_data", bus.MemWData, 32'h0);
        chk("split_cnt", split_cnt, exp_split);
    endtask

    initial begin
        int seen;
        logic [1:0] t;
        logic [31:0] a, d;
        CPU_RST       = 1'b0;
        bus.ReqValid  = 1'b0;
        bus.StoreType = NOSTORE;
        bus.Addr      = '0;
        bus.WData     = '0;
        #1 CPU_RST = 1'b1;
        #1;
        chk("rst_ready", bus.ReqReady, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bus.MemValid, 1'b0);
        chk("rst_addr", bus.MemAddr, 32'h0);
        chk("rst_we", bus.MemWE, 4'b0000);
        chk("rst_cnt", split_cnt, '0);
        repeat (2) @(posedge CPU_CLK);
        #2 CPU_RST = 1'b0;
        @(negedge CPU_CLK);
        chk("rel_ready", bus.ReqReady, 1'b1);

        stall_n = 0;
        push_beat(32'h100, 32'hDEADBEEF, 4'b1111);
        send(SW, 32'h100, 32'hDEADBEEF);
        drain();

        push_beat(32'h200, 32'hA5000000, 4'b1000);
        send(SB, 32'h203, 32'h000000A5);
        push_beat(32'h200, 32'h12340000, 4'b1100);
        send(SH, 32'h202, 32'h00001234);
        drain();

        push_beat(32'h300, 32'h22334400, 4'b1110);
        push_beat(32'h304, 32'h00000011, 4'b0001);
        bump_split();
        send(SW, 32'h301, 32'h11223344);
        drain();
        push_beat(32'hFFFFFFFC, 32'hCCDD0000, 4'b1100);
        push_beat(32'h00000000, 32'h0000AABB, 4'b0011);
        bump_split();
        send(SW, 32'hFFFFFFFE, 32'hAABBCCDD);
        drain();

        stall_n = 3;
        push_beat(32'h400, 32'hEF000000, 4'b1000);
        push_beat(32'h404, 32'h000000BE, 4'b0001);
        bump_split();
        send(SH, 32'h403, 32'h0000BEEF);
        drain();

        for (int i = 0; i < 24; i++) begin
            stall_n = $urandom_range(0, 2);
            t = 2'($urandom_range(0, 3));
            a = $urandom;
            d = $urandom;
            model(t, a, d);
            send(t, a, d);
            drain();
        end

        // Reset lands mid-store while beat 0 is stalled; beat 1 must never appear.
        stall_n = 1000;
        send(SW, 32'h301, 32'h11223344);
        repeat (2) @(posedge CPU_CLK);
        #3 CPU_RST = 1'b1;
        #1;
        chk("arst_valid", bus.MemValid, 1'b0);
        chk("arst_we", bus.MemWE, 4'b0000);
        chk("arst_data", bus.MemWData, 32'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_cnt", split_cnt, '0);
        chk("arst_ready", bus.ReqReady, 1'b0);
        exp_q.delete();
        exp_split = '0;
        seen = beats_seen;
        repeat (2) @(posedge CPU_CLK);
        #2 CPU_RST = 1'b0;
        stall_n = 0;
        @(negedge CPU_CLK);
        chk("arel_ready", bus.ReqReady, 1'b1);
        repeat (5) @(negedge CPU_CLK);
        chk("no_beat1", beats_seen, seen);
        send(NOSTORE, 32'h500, 32'h12345678);
        repeat (4) @(negedge CPU_CLK);
        chk("nostore_beats", beats_seen, seen);
        chk("nostore_valid", bus.MemValid, 1'b0);
        chk("final_cnt", split_cnt, exp_split);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
STORE_ALIGN_UNIT -- requirements
Module: store_align_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of split-store counter.
REQ-002 SHALL have port CPU_CLK  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port CPU_RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ReqValid  input  1  store request valid.
REQ-005 SHALL have port ReqReady  output  1  unit can accept request this cycle.
REQ-006 SHALL have port StoreType  input  2  `NOSTORE/`SB/`SH/`SW.
REQ-007 SHALL have port Addr  input  32  byte address of store.
REQ-008 SHALL have port WData  input  32  register data, LSB-justified.
REQ-009 SHALL have port MemValid  output  1  memory write beat valid.
REQ-010 SHALL have port MemReady  input  1  memory accepts beat this cycle.
REQ-011 SHALL have port MemAddr  output  32  word address, bits [1:0] always 0.
REQ-012 SHALL have port MemWData  output  32  lane-aligned write data.
REQ-013 SHALL have port MemWE  output  4  byte enables, bit i = byte lane i.
REQ-014 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port SplitCnt  output  CNT_W  count of stores that needed two beats.

Function
REQ-016 SHALL accept a request on the cycle ReqValid && ReqReady; ReqReady = 1 only in IDLE.
REQ-017 SHALL form size mask 0001 (SB), 0011 (SH), 1111 (SW), off = Addr[1:0]; 8-byte data = {32'b0,WData} << 8*off; 8-bit enables = mask << off.
REQ-018 SHALL, when upper 4 enable bits are zero, issue one beat: MemAddr = {Addr[31:2],2'b00}, lower data/enables.
REQ-019 SHALL, when upper enable bits are nonzero (misaligned SH at off 3, SW at off 1..3), issue beat 0 with lower half, then beat 1 at MemAddr+4 with upper half.
REQ-020 SHALL compute beat-1 address modulo 2^32 (0xFFFFFFFC + 4 wraps to 0x00000000).
REQ-021 SHALL use FSM IDLE -> BEAT0 on accept; BEAT0 -> IDLE on MemReady if single, BEAT0 -> BEAT1 on MemReady if split; BEAT1 -> IDLE on MemReady.
REQ-022 SHALL register all Mem* outputs; MemValid rises the cycle after accept (latency 1).
REQ-023 SHALL hold MemAddr, MemWData, MemWE stable while MemValid && !MemReady.
REQ-024 SHALL drive MemValid = 0, MemWE = 0000, MemWData = 0 in IDLE.
REQ-025 SHALL accept and discard `NOSTORE requests in IDLE: no beat, state stays IDLE.
REQ-026 SHALL not accept a new request in the cycle the last beat completes; next accept earliest the following cycle (one idle cycle between stores).
REQ-027 SHALL increment SplitCnt by 1 on acceptance of a split store, saturating at all-ones.
REQ-028 SHALL ignore ReqValid, StoreType, Addr, WData while Busy.

Reset
REQ-029 SHALL, on CPU_RST high, immediately force IDLE, MemValid 0, MemWE 0000, MemAddr 0, MemWData 0, SplitCnt 0, Busy 0, regardless of edge or in-flight beat.
REQ-030 SHALL drop an in-flight store aborted by reset; no beat 1 after reset release.
REQ-031 SHALL have ReqReady = 0 while CPU_RST high, 1 on first cycle after release.

Structure
REQ-032 SHALL take `NOSTORE=2'b00, `SB=2'b01, `SH=2'b10, `SW=2'b11 from Parameters.v alongside load-type constants; FSM state encodings local.
REQ-033 SHALL keep lane shift/enable generation in one combinational sub-module store_lane_shift (inputs StoreType, off, WData; outputs 64-bit data, 8-bit enables).

Verification
REQ-034 SW Addr=0x100, WData=0xDEADBEEF, MemReady=1 -> one beat: MemAddr 0x100, MemWData 0xDEADBEEF, MemWE 1111, MemValid one cycle after accept, SplitCnt 0.
REQ-035 SB Addr=0x203, WData=0x000000A5 -> MemAddr 0x200, MemWData 0xA5000000, MemWE 1000; SH Addr=0x202, WData=0x1234 -> MemWData 0x12340000, MemWE 1100.
REQ-036 SW Addr=0x301, WData=0x11223344 -> beat0 0x300/0x22334400/1110, beat1 0x304/0x00000011/0001, SplitCnt 1; SW Addr=0xFFFFFFFE -> beat1 MemAddr 0x00000000, MemWE 0011.
REQ-037 SH Addr=0x403, MemReady low 3 cycles per beat -> outputs stable while stalled, ReqReady 0 throughout, two beats 0x400/1000, 0x404/0001.
REQ-038 Assert CPU_RST asynchronously mid-split between beat0 and beat1 -> MemValid 0 immediately, no beat 1, SplitCnt 0; `NOSTORE request afterwards -> no beat.
